// File: rtl/prog_loader_if.sv
// Bus bundle between the program loader and its host/core environment.
// The loader takes the master view: it consumes the byte stream and the
// core's halt, and drives the instruction-RAM write port, the launch strobe
// and the status outputs. The slave view is the mirror for the environment.

interface prog_loader_if #(
    parameter int IW = 9,
    parameter int AW = 8
);
    logic          load_req;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_wdata;
    logic          start;
    logic          halt;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   cycle_count;

    modport master (
        input  load_req,
        input  byte_valid,
        input  byte_data,
        input  halt,
        output byte_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata,
        output start,
        output busy,
        output done,
        output err,
        output cycle_count
    );

    modport slave (
        output load_req,
        output byte_valid,
        output byte_data,
        output halt,
        input  byte_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata,
        input  start,
        input  busy,
        input  done,
        input  err,
        input  cycle_count
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: unpacks a length-prefixed byte stream into 9-bit
// instructions, writes them to instruction RAM, launches the core and
// measures how many cycles the core runs before it halts.
//
// Stream: first byte L announces L+1 words; each word is a low byte
// (inst[7:0]) followed by a high byte whose bit 0 is inst[8] and whose
// upper seven bits must be zero, otherwise the load aborts into ERR.
// All outputs except byte_ready come straight from flops so the RAM and
// core see glitch-free strobes; byte_ready is a pure state decode so a
// byte can be taken in the very first cycle of LEN/LO/HI.

module prog_loader #(
    parameter int IW        = 9,
    parameter int AW        = 8,
    parameter int START_CYC = 2
) (
    input  logic            CLK,
    input  logic            reset,
    prog_loader_if.master   bus
);

    localparam int SCW = (START_CYC > 1) ? $clog2(START_CYC) : 1;
    localparam logic [SCW-1:0] SC_LAST = SCW'(START_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LEN   = 4'd1,
        S_LO    = 4'd2,
        S_HI    = 4'd3,
        S_WRITE = 4'd4,
        S_START = 4'd5,
        S_RUN   = 4'd6,
        S_DONE  = 4'd7,
        S_ERR   = 4'd8
    } state_t;

    // Run-length counter increments but sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

    // Control state
    state_t          state_q, state_d;
    logic [AW-1:0]   len_q, len_d;
    logic [AW-1:0]   ptr_q, ptr_d;
    logic [7:0]      lo_q, lo_d;
    logic            hi_q, hi_d;
    logic [SCW-1:0]  scnt_q, scnt_d;
    logic            run_first_q, run_first_d;
    logic [15:0]     cnt_q, cnt_d;

    // Registered outputs
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [IW-1:0]   wdata_q, wdata_d;
    logic            start_q, start_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            ready_s;
    logic            xfer_s;

    // Bytes are only accepted while parsing the stream header or a word.
    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            S_LEN, S_LO, S_HI: ready_s = 1'b1;
            default:           ready_s = 1'b0;
        endcase
    end

    assign xfer_s = bus.byte_valid && ready_s;

    // Next-state and datapath decisions for the load / launch / run sequence.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ptr_d       = ptr_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        scnt_d      = scnt_q;
        run_first_d = run_first_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // A fresh load wipes the previous result and error.
                if (bus.load_req) begin
                    state_d = S_LEN;
                    ptr_d   = '0;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_LEN: begin
                if (xfer_s) begin
                    len_d   = AW'(bus.byte_data);
                    state_d = S_LO;
                end else begin
                    state_d = S_LEN;
                end
            end
            S_LO: begin
                if (xfer_s) begin
                    lo_d    = bus.byte_data;
                    state_d = S_HI;
                end else begin
                    state_d = S_LO;
                end
            end
            S_HI: begin
                if (xfer_s) begin
                    if (bus.byte_data[7:1] != 7'd0) begin
                        state_d = S_ERR;
                    end else begin
                        hi_d    = bus.byte_data[0];
                        state_d = S_WRITE;
                    end
                end else begin
                    state_d = S_HI;
                end
            end
            S_WRITE: begin
                // The last word is the one whose index equals L, so the
                // pointer stops at 255 for a full 256-word image.
                if (ptr_q == len_q) begin
                    scnt_d  = '0;
                    state_d = S_START;
                end else begin
                    ptr_d   = ptr_q + AW'(1);
                    state_d = S_LO;
                end
            end
            S_START: begin
                if (scnt_q == SC_LAST) begin
                    run_first_d = 1'b1;
                    state_d     = S_RUN;
                end else begin
                    scnt_d  = scnt_q + SCW'(1);
                    state_d = S_START;
                end
            end
            S_RUN: begin
                run_first_d = 1'b0;
                if (bus.halt) begin
                    if (run_first_q) begin
                        cnt_d = 16'd0;
                    end else begin
                        cnt_d = cnt_q;
                    end
                    state_d = S_DONE;
                end else begin
                    if (run_first_q) begin
                        cnt_d = 16'd1;
                    end else begin
                        cnt_d = sat_inc16(cnt_q);
                    end
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs are derived from the upcoming state so they are valid
    // from the first cycle of that state and come from flops.
    always_comb begin
        we_d    = (state_d == S_WRITE);
        start_d = (state_d == S_START);
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
        busy_d  = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
        if (we_d) begin
            addr_d  = ptr_d;
            wdata_d = IW'({hi_d, lo_d});
        end else begin
            addr_d  = '0;
            wdata_d = '0;
        end
    end

    // Control state registers; reset returns to IDLE at once.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            ptr_q       <= '0;
            lo_q        <= 8'd0;
            hi_q        <= 1'b0;
            scnt_q      <= '0;
            run_first_q <= 1'b0;
            cnt_q       <= 16'd0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ptr_q       <= ptr_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            scnt_q      <= scnt_d;
            run_first_q <= run_first_d;
            cnt_q       <= cnt_d;
        end
    end

    // Output registers; reset kills any write or launch strobe immediately.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.byte_ready  = ready_s;
    assign bus.imem_we     = we_q;
    assign bus.imem_addr   = addr_q;
    assign bus.imem_wdata  = wdata_q;
    assign bus.start       = start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: directed stimulus, a stream-level reference model
// checked every cycle, and literal expectations per scenario.

module tb_prog_loader;

    localparam int START_CYC = 2;

    logic clk;
    logic reset;

    prog_loader_if #(.IW(9), .AW(8)) bus ();

    prog_loader #(.IW(9), .AW(8), .START_CYC(START_CYC)) dut (
        .CLK   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Writes actually seen on the RAM port
    int log_addr[$];
    int log_data[$];
    // Words to send for the current stream
    logic [8:0] words_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (stream level) ----------------
    // ph: 0 quiescent, 1 taking bytes, 2 write cycle, 3 launch, 4 core running
    int         ph = 0;
    bit         m_done = 0, m_err = 0;
    int         m_cnt = 0;
    int         m_nw = 0, m_widx = 0, m_scnt = 0;
    bit         m_got_len = 0, m_want_lo = 1;
    logic [7:0] m_lo = 8'd0;
    logic       m_hi = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                ph = 0; m_done = 0; m_err = 0; m_cnt = 0;
            end
            chk("byte_ready", {31'd0, bus.byte_ready}, {31'd0, ph == 1});
            chk("imem_we",    {31'd0, bus.imem_we},    {31'd0, ph == 2});
            chk("imem_addr",  {24'd0, bus.imem_addr},  (ph == 2) ? m_widx : 0);
            chk("imem_wdata", {23'd0, bus.imem_wdata}, (ph == 2) ? {23'd0, m_hi, m_lo} : 32'd0);
            chk("start",      {31'd0, bus.start},      {31'd0, ph == 3});
            chk("busy",       {31'd0, bus.busy},       {31'd0, ph != 0});
            chk("done",       {31'd0, bus.done},       {31'd0, m_done});
            chk("err",        {31'd0, bus.err},        {31'd0, m_err});
            chk("cycle_count",{16'd0, bus.cycle_count}, m_cnt);
            if (bus.imem_we && !reset) begin
                log_addr.push_back(int'(bus.imem_addr));
                log_data.push_back(int'(bus.imem_wdata));
            end
            if (!reset) begin
                case (ph)
                    0: if (bus.load_req) begin
                        ph = 1; m_done = 0; m_err = 0; m_cnt = 0;
                        m_got_len = 0; m_want_lo = 1; m_widx = 0;
                    end
                    1: if (bus.byte_valid) begin
                        if (!m_got_len) begin
                            m_nw = int'(bus.byte_data) + 1; m_got_len = 1;
                        end else if (m_want_lo) begin
                            m_lo = bus.byte_data; m_want_lo = 0;
                        end else if (bus.byte_data[7:1] != 7'd0) begin
                            ph = 0; m_err = 1;
                        end else begin
                            m_hi = bus.byte_data[0]; ph = 2;
                        end
                    end
                    2: begin
                        m_want_lo = 1;
                        if (m_widx == m_nw - 1) begin ph = 3; m_scnt = 0; end
                        else begin m_widx++; ph = 1; end
                    end
                    3: begin
                        m_scnt++;
                        if (m_scnt == START_CYC) ph = 4;
                    end
                    4: if (bus.halt) begin ph = 0; m_done = 1; end
                       else if (m_cnt < 65535) m_cnt++;
                    default: ph = 0;
                endcase
            end
        end
    end

    // ---------------- stimulus helpers (entered at posedge+1) ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        bus.byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.byte_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        bus.byte_valid = 1'b0;
        chk("byte_accept_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_word(input logic [8:0] w, input bit gaps);
        send_byte(w[7:0], gaps ? int'($urandom_range(0, 1)) : 0);
        send_byte({7'd0, w[8]}, gaps ? int'($urandom_range(0, 1)) : 0);
    endtask

    task automatic send_stream(input bit gaps);
        send_byte(8'(words_q.size() - 1), gaps ? int'($urandom_range(0, 1)) : 0);
        foreach (words_q[i]) send_word(words_q[i], gaps);
    endtask

    task automatic do_load();
        bus.load_req = 1'b1;
        @(posedge clk); #1;
        bus.load_req = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (bus.done) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        chk("done_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_start();
        bit ok;
        ok = 0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.start) begin ok = 1; break; end
        end
        chk("start_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_t1_log(input string tag);
        chk({tag, "_nwrites"}, log_addr.size(), 32'd3);
        if (log_addr.size() == 3) begin
            chk({tag, "_a0"}, log_addr[0], 32'd0);
            chk({tag, "_a1"}, log_addr[1], 32'd1);
            chk({tag, "_a2"}, log_addr[2], 32'd2);
            chk({tag, "_d0"}, log_data[0], 32'h1A3);
            chk({tag, "_d1"}, log_data[1], 32'h045);
            chk({tag, "_d2"}, log_data[2], 32'h100);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        reset = 1'b1;
        bus.load_req = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = 8'd0; bus.halt = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_busy",  {31'd0, bus.busy}, 32'd0);
        chk("rst_done",  {31'd0, bus.done}, 32'd0);
        chk("rst_err",   {31'd0, bus.err}, 32'd0);
        chk("rst_start", {31'd0, bus.start}, 32'd0);
        chk("rst_we",    {31'd0, bus.imem_we}, 32'd0);
        chk("rst_count", {16'd0, bus.cycle_count}, 32'd0);

        // 1: three words, halt already high at launch -> count 0
        words_q = '{9'h1A3, 9'h045, 9'h100};
        log_addr.delete(); log_data.delete();
        do_load();
        send_stream(1'b0);
        bus.halt = 1'b1;
        wait_done();
        bus.halt = 1'b0;
        check_t1_log("t1");
        chk("t1_count0", {16'd0, bus.cycle_count}, 32'd0);

        // 2: same stream with random byte_valid gaps
        log_addr.delete(); log_data.delete();
        do_load();
        send_stream(1'b1);
        bus.halt = 1'b1;
        wait_done();
        bus.halt = 1'b0;
        check_t1_log("t2");

        // 3: malformed high byte on word 1, then recover
        log_addr.delete(); log_data.delete();
        do_load();
        send_byte(8'd2, 0);
        send_word(9'h1A3, 1'b0);
        send_byte(8'h45, 0);
        send_byte(8'h02, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_err",     {31'd0, bus.err}, 32'd1);
        chk("t3_ready",   {31'd0, bus.byte_ready}, 32'd0);
        chk("t3_nwrites", log_addr.size(), 32'd1);
        log_addr.delete(); log_data.delete();
        words_q = '{9'h1A3, 9'h045, 9'h100};
        do_load();
        chk("t3_err_clr", {31'd0, bus.err}, 32'd0);
        send_stream(1'b0);
        bus.halt = 1'b1;
        wait_done();
        bus.halt = 1'b0;
        check_t1_log("t3r");

        // 4: halt on the 11th RUN cycle, load_req ignored mid-run
        log_addr.delete(); log_data.delete();
        words_q = '{9'h0AA};
        do_load();
        send_stream(1'b0);
        wait_start();
        @(negedge clk);
        @(posedge clk); #1;            // RUN cycle 1
        repeat (4) @(posedge clk); #1; // RUN cycle 5
        bus.load_req = 1'b1;
        @(posedge clk); #1;            // RUN cycle 6
        bus.load_req = 1'b0;
        chk("t4_busy_mid", {31'd0, bus.busy}, 32'd1);
        repeat (5) @(posedge clk); #1; // RUN cycle 11
        bus.halt = 1'b1;
        wait_done();
        bus.halt = 1'b0;
        chk("t4_count", {16'd0, bus.cycle_count}, 32'd10);
        chk("t4_done",  {31'd0, bus.done}, 32'd1);

        // 5: full 256-word image, then saturating run length
        log_addr.delete(); log_data.delete();
        words_q.delete();
        for (int i = 0; i < 256; i++) words_q.push_back({i[0], i[7:0] ^ 8'h5A});
        do_load();
        send_stream(1'b0);
        repeat (70000) @(posedge clk);
        #1 bus.halt = 1'b1;
        wait_done();
        bus.halt = 1'b0;
        chk("t5_nwrites", log_addr.size(), 32'd256);
        if (log_addr.size() == 256) begin
            chk("t5_last_addr", log_addr[255], 32'd255);
            chk("t5_last_data", log_data[255], 32'h1A5);
        end
        chk("t5_sat", {16'd0, bus.cycle_count}, 32'h0000FFFF);

        // 6: reset between low and high byte of word 5, then a fresh load
        log_addr.delete(); log_data.delete();
        do_load();
        send_byte(8'd9, 0);
        for (int i = 0; i < 5; i++) send_word(9'(i * 37 + 5), 1'b0);
        send_byte(8'h77, 0);
        reset = 1'b1;
        #1;
        chk("t6_we_rst",    {31'd0, bus.imem_we}, 32'd0);
        chk("t6_start_rst", {31'd0, bus.start}, 32'd0);
        chk("t6_busy_rst",  {31'd0, bus.busy}, 32'd0);
        chk("t6_ready_rst", {31'd0, bus.byte_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("t6_nwrites", log_addr.size(), 32'd5);
        if (log_addr.size() == 5) chk("t6_addr4", log_addr[4], 32'd4);
        log_addr.delete(); log_data.delete();
        repeat (3) @(posedge clk); #1;
        chk("t6_no_write", log_addr.size(), 32'd0);
        words_q = '{9'h1FF};
        do_load();
        send_stream(1'b0);
        bus.halt = 1'b1;
        wait_done();
        bus.halt = 1'b0;
        chk("t6_fresh_n", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) begin
            chk("t6_fresh_addr", log_addr[0], 32'd0);
            chk("t6_fresh_data", log_data[0], 32'h1FF);
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
